// File: rtl/dcache_pkg.sv
// ============================================================================
// dcache_pkg : shared state encoding and geometry for the L1 data cache
// Rev 1.0
// ============================================================================
`default_nettype none

package dcache_pkg;

    localparam int TAG_W    = 23;
    localparam int INDEX_W  = 4;
    localparam int OFFSET_W = 5;
    localparam int LINE_W   = 256;
    localparam int WORD_W   = 32;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        MISS       = 3'd1,
        WRITEBACK  = 3'd2,
        READMISS   = 3'd3,
        READMISSOK = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dcache_sram.sv
// ============================================================================
// dcache_sram : tag/valid/dirty/data arrays, combinational read, sync write
// Rev 1.0
// ============================================================================
`default_nettype none

module dcache_sram
    import dcache_pkg::*;
#(
    parameter int LINES    = 16,
    parameter int LINE_W   = 256,
    parameter int TAG_BITS = 23
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [$clog2(LINES)-1:0]    index,
    output logic [TAG_BITS-1:0]         rd_tag,
    output logic                        rd_valid,
    output logic                        rd_dirty,
    output logic [LINE_W-1:0]           rd_data,
    input  logic                        line_we,
    input  logic [TAG_BITS-1:0]         line_tag,
    input  logic [LINE_W-1:0]           line_data,
    input  logic                        word_we,
    input  logic [$clog2(LINE_W/WORD_W)-1:0] word_sel,
    input  logic [WORD_W-1:0]           word_data
);

    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [LINE_W-1:0]   data_mem [LINES];
    logic [LINES-1:0]    valid;
    logic [LINES-1:0]    dirty;

    assign rd_tag   = tag_mem[index];
    assign rd_data  = data_mem[index];
    assign rd_valid = valid[index];
    assign rd_dirty = dirty[index];

    // Payload arrays carry no reset; only the status bits are cleared.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[index]  <= line_tag;
            data_mem[index] <= line_data;
        end else if (word_we) begin
            data_mem[index][word_sel*WORD_W +: WORD_W] <= word_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            dirty <= '0;
        end else if (line_we) begin
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
        end else if (word_we) begin
            dirty[index] <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dcache_ctrl.sv
// ============================================================================
// dcache_ctrl : direct-mapped write-back write-allocate L1 D-cache controller
// Rev 1.0
// ============================================================================
`default_nettype none

module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int LINE_W = 256
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [31:0]         cpu_addr_i,
    input  logic [31:0]         cpu_data_i,
    input  logic                cpu_MemRead_i,
    input  logic                cpu_MemWrite_i,
    output logic [31:0]         cpu_data_o,
    output logic                cpu_stall_o,
    output logic [31:0]         mem_addr_o,
    output logic [LINE_W-1:0]   mem_data_o,
    output logic                mem_enable_o,
    output logic                mem_write_o,
    input  logic [LINE_W-1:0]   mem_data_i,
    input  logic                mem_ack_i
);

    localparam int OFF_W    = $clog2(LINE_W / 8);
    localparam int IDX_W    = $clog2(LINES);
    localparam int TAG_BITS = 32 - IDX_W - OFF_W;
    localparam int WSEL_W   = $clog2(LINE_W / WORD_W);

    state_t                 state;
    logic [TAG_BITS-1:0]    req_tag;
    logic [IDX_W-1:0]       req_index;
    logic [WSEL_W-1:0]      req_word;
    logic [TAG_BITS-1:0]    rd_tag;
    logic                   rd_valid;
    logic                   rd_dirty;
    logic [LINE_W-1:0]      rd_data;
    logic                   req;
    logic                   hit;
    logic                   line_we;
    logic                   word_we;
    logic                   unused_addr_bits;

    assign req_tag          = cpu_addr_i[31 -: TAG_BITS];
    assign req_index        = cpu_addr_i[OFF_W +: IDX_W];
    assign req_word         = cpu_addr_i[2 +: WSEL_W];
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    assign req         = cpu_MemRead_i | cpu_MemWrite_i;
    assign hit         = rd_valid & (rd_tag == req_tag);
    assign cpu_stall_o = req & ~hit;
    assign cpu_data_o  = hit ? rd_data[req_word*WORD_W +: WORD_W] : 32'd0;

    // A store can only hit in IDLE or READMISSOK, so it never collides with a refill.
    assign word_we = cpu_MemWrite_i & hit;
    assign line_we = (state == READMISS) & mem_ack_i;

    dcache_sram #(
        .LINES    (LINES),
        .LINE_W   (LINE_W),
        .TAG_BITS (TAG_BITS)
    ) u_sram (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .index     (req_index),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_data   (rd_data),
        .line_we   (line_we),
        .line_tag  (req_tag),
        .line_data (mem_data_i),
        .word_we   (word_we),
        .word_sel  (req_word),
        .word_data (cpu_data_i)
    );

    // Memory-side outputs are loaded on the edge that enters each state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= 32'd0;
            mem_data_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_stall_o) state <= MISS;
                end
                MISS: begin
                    mem_enable_o <= 1'b1;
                    if (rd_valid & rd_dirty) begin
                        state       <= WRITEBACK;
                        mem_write_o <= 1'b1;
                        mem_addr_o  <= {rd_tag, req_index, {OFF_W{1'b0}}};
                        mem_data_o  <= rd_data;
                    end else begin
                        state       <= READMISS;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {req_tag, req_index, {OFF_W{1'b0}}};
                        mem_data_o  <= '0;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        state       <= READMISS;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {req_tag, req_index, {OFF_W{1'b0}}};
                        mem_data_o  <= '0;
                    end
                end
                READMISS: begin
                    if (mem_ack_i) begin
                        state        <= READMISSOK;
                        mem_enable_o <= 1'b0;
                        mem_addr_o   <= 32'd0;
                    end
                end
                READMISSOK: begin
                    state <= IDLE;
                end
                default: begin
                    state        <= IDLE;
                    mem_enable_o <= 1'b0;
                    mem_write_o  <= 1'b0;
                    mem_addr_o   <= 32'd0;
                    mem_data_o   <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate L1 data cache controller that sits between the pipelined CPU's MEM stage and the off-chip data memory. It replaces the CPU's direct Data_Memory connection. It serves word loads and stores from a 16-line × 256-bit array with zero-cycle hit latency. On a miss it stalls the whole pipeline while a miss FSM writes back any dirty victim and refills the line.

## Interface
Parameters:
- LINES, 16, number of cache lines (index width = log2(LINES) = 4)
- LINE_W, 256, line width in bits (32 bytes, 8 words)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-low reset
- cpu_addr_i  in  32  byte address from MEM stage (ALU result); bits [1:0] ignored
- cpu_data_i  in  32  store data
- cpu_MemRead_i  in  1  load request, held while stalled
- cpu_MemWrite_i  in  1  store request, held while stalled
- cpu_data_o  out  32  load data
- cpu_stall_o  out  1  freeze PC, IF_ID, ID_EXE, EXE_MEM and MEM_WB
- mem_addr_o  out  32  line-aligned memory address ([4:0]=0)
- mem_data_o  out  256  victim line for writeback
- mem_enable_o  out  1  memory request, held until ack
- mem_write_o  out  1  1=write line, 0=read line
- mem_data_i  in  256  refill line, valid when mem_ack_i=1
- mem_ack_i  in  1  one-cycle completion pulse

## Operation
- Address split:
  - tag = addr[31:9] (23 bits)
  - index = addr[8:5]
  - word = addr[4:2]
- Per line: valid, dirty, tag[22:0], data[255:0].
- req = MemRead | MemWrite. Both high counts as a store.
- hit = valid[index] & (tag[index] == tag). Computed combinationally.
- cpu_stall_o = req & ~hit, combinational, in every state.
- cpu_data_o = data[index] word `word` when hit, else 0.
- Store hit: at the clock edge, write the word, set dirty=1. Other words are unchanged.
- FSM states: IDLE, MISS, WRITEBACK, READMISS, READMISSOK.
  - IDLE: if req & ~hit, go to MISS. Otherwise stay.
  - MISS: if valid & dirty of the victim, go to WRITEBACK. Otherwise go to READMISS.
  - WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=victim line. On mem_ack_i, go to READMISS.
  - READMISS: mem_enable_o=1, mem_write_o=0, mem_addr_o={req tag, index, 5'b0}. On mem_ack_i, at that edge: data←mem_data_i, tag←req tag, valid←1, dirty←0; go to READMISSOK.
  - READMISSOK: the line now hits and stall drops. Any store is applied at this edge (dirty←1). Go to IDLE.
- mem_enable_o and mem_write_o are Moore outputs: 0 in IDLE, MISS and READMISSOK. mem_addr_o and mem_data_o are 0 when mem_enable_o=0.
- mem_ack_i is ignored outside WRITEBACK and READMISS.
- Reset: asynchronous, takes effect immediately, including mid-miss. Effects:
  - FSM → IDLE
  - all valid and dirty bits ← 0
  - mem_enable_o, mem_write_o, mem_addr_o and mem_data_o ← 0
  - Data and tag arrays are not reset.
- cpu_data_o and cpu_stall_o then follow from the cleared arrays: 0 with no request, 1 for stall with a request.

## Timing
- Hit: 0-cycle latency. Data is valid in the same cycle as the request, and stall stays low.
- Clean miss, with the request in IDLE at cycle 0:
  - cycle 1: MISS
  - cycle 2: READMISS, mem_enable_o rises; ack arrives at cycle A
  - cycle A+1: READMISSOK, stall=0, data valid
  - cycle A+2: IDLE
- Dirty miss: WRITEBACK is inserted between MISS and READMISS. READMISS starts the cycle after the writeback ack, so enable stays high continuously across the transition and only mem_write_o and mem_addr_o change.
- Request inputs must stay stable while cpu_stall_o=1. The CPU guarantees this because its pipeline is frozen.

## Structure
- Shared package dcache_pkg holds:
  - the state enum (IDLE, MISS, WRITEBACK, READMISS, READMISSOK)
  - TAG_W=23, INDEX_W=4, OFFSET_W=5, LINE_W=256
- Sub-module dcache_sram holds the arrays:
  - combinational read of tag, valid, dirty and data at the index
  - synchronous write enable with full-line or single-word write
  - asynchronous active-low clear of valid and dirty
- The controller owns the FSM, hit logic and word select.

## Test plan
- Cold load: after reset, load 0x0000_0040. Memory model acks 10 cycles after enable with 8 known words. Required: stall high for 13 cycles, a read request to 0x40, then cpu_data_o equals word 0 and the line is valid and clean.
- Store hit then load: store 0xDEADBEEF to 0x44 on the now-resident line. Required: no stall and dirty=1. A following load of 0x44 returns 0xDEADBEEF in the same cycle.
- Dirty eviction: load 0x0000_0240 (same index 2, tag 1). Required:
  - WRITEBACK with mem_addr_o=0x40 and mem_data_o word 1 = 0xDEADBEEF
  - then READMISS at 0x240, with mem_enable_o high throughout
- Store miss: store 0x12345678 to 0x0000_0480 on a clean line. Required:
  - refill is followed by the word merged at READMISSOK
  - dirty=1, remaining 7 words equal memory
- Reset mid-refill: assert rst_i low during READMISS. Required: mem_enable_o=0 immediately, FSM in IDLE, and a re-issued load misses again.
- Spurious ack: pulse mem_ack_i while in IDLE. Required: no state or array change.
